// File: rtl/exu_wb_queue.sv
// Writeback result queue between one EXU result port and the CDB arbiter.
// Latency: a pushed result requests the CDB the cycle after the push (no empty bypass).
// Backpressure: in_rdy = ~full, independent of cdb_rdy; head tag/data hold while not granted.
module exu_wb_queue #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [DATA_W-1:0]          in_wdata,
  output logic                       cdb_req,
  input  logic                       cdb_rdy,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_wdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is deliberately not reset; occupancy is tracked by count_q alone.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic [ENT_W-1:0] head;

  // Full/empty derive from count, so pointers may wrap freely.
  assign in_rdy  = (count_q != FULL_CNT);
  assign cdb_req = (count_q != '0);
  assign push    = in_vld & in_rdy;
  assign pop     = cdb_req & cdb_rdy;
  assign count   = count_q;

  // Head comes straight from registered state; zeroed when the queue is empty.
  assign head      = mem_q[rd_ptr_q];
  assign cdb_tag   = cdb_req ? head[ENT_W-1:DATA_W] : '0;
  assign cdb_wdata = cdb_req ? head[DATA_W-1:0]     : '0;

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; a push that coincides with flush or reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      mem_q[wr_ptr_q] <= {in_tag, in_wdata};
    end
  end

  // Occupancy sanity: never overfilled, never pushed when full, never popped when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (count_q <= FULL_CNT);
      assert (!(push && (count_q == FULL_CNT)));
      assert (!(pop && (count_q == '0)));
    end
  end

endmodule

// File: tb/tb_exu_wb_queue.sv
// Bench for exu_wb_queue: directed scenarios plus random traffic.
// A queue-based reference model in the monitor predicts occupancy and head order.
// Inputs change 1 ns after posedge; the monitor samples on negedge.
module tb_exu_wb_queue;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [DATA_W-1:0] in_wdata = '0;
  logic              cdb_req;
  logic              cdb_rdy = 1'b0;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_wdata;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Expected contents of the queue, oldest first: {tag, data}.
  logic [TAG_W+DATA_W-1:0] exp_q[$];

  exu_wb_queue #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_tag(in_tag), .in_wdata(in_wdata),
    .cdb_req(cdb_req), .cdb_rdy(cdb_rdy), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = exp_q.size();
      chk("mon_count", 64'(count), 64'(sz));
      chk("mon_cdb_req", 64'(cdb_req), 64'(sz != 0));
      chk("mon_in_rdy", 64'(in_rdy), 64'(sz < DEPTH));
      if (sz != 0) begin
        chk("mon_head_tag", 64'(cdb_tag), 64'(exp_q[0][TAG_W+DATA_W-1:DATA_W]));
        chk("mon_head_data", 64'(cdb_wdata), 64'(exp_q[0][DATA_W-1:0]));
      end else begin
        chk("mon_empty_tag", 64'(cdb_tag), 64'd0);
        chk("mon_empty_data", 64'(cdb_wdata), 64'd0);
      end
      if (!rst || flush) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && cdb_rdy) void'(exp_q.pop_front());
        if (in_vld && sz < DEPTH) exp_q.push_back({in_tag, in_wdata});
      end
    end
  end

  initial begin
    // 1: reset held two cycles with in_vld asserted
    rst = 1'b0; in_vld = 1'b1; in_tag = 4'd7; in_wdata = 32'h1234_5678;
    tick();
    tick();
    mon_en = 1'b1;
    in_vld = 1'b0;
    rst = 1'b1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_req", 64'(cdb_req), 64'd0);
    chk("reset_in_rdy", 64'(in_rdy), 64'd1);
    chk("reset_tag", 64'(cdb_tag), 64'd0);
    tick();

    // 2: single result with grant waiting
    cdb_rdy = 1'b1;
    in_vld = 1'b1; in_tag = 4'd3; in_wdata = 32'hDEAD_BEEF;
    tick();
    in_vld = 1'b0;
    chk("lat_req", 64'(cdb_req), 64'd1);
    chk("lat_tag", 64'(cdb_tag), 64'd3);
    chk("lat_data", 64'(cdb_wdata), 64'hDEAD_BEEF);
    tick();
    chk("lat_count", 64'(count), 64'd0);

    // 3: fill under backpressure, then drain in order
    cdb_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_vld = 1'b1; in_tag = 4'(i); in_wdata = 32'(i * 32'h1111);
      tick();
      chk("full_head_hold", 64'(cdb_tag), 64'd1);
    end
    in_tag = 4'd5; in_wdata = 32'h5555;
    tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_rdy", 64'(in_rdy), 64'd0);
    chk("full_head_after5", 64'(cdb_tag), 64'd1);
    in_vld = 1'b0;
    cdb_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_tag", 64'(cdb_tag), 64'(i));
      tick();
    end
    chk("drain_count", 64'(count), 64'd0);

    // 4: steady push+pop at occupancy two across pointer wrap
    cdb_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1; in_tag = 4'(i); in_wdata = 32'hA000 + 32'(i);
      tick();
    end
    cdb_rdy = 1'b1;
    for (int i = 2; i < 10; i++) begin
      in_tag = 4'(i); in_wdata = 32'hA000 + 32'(i);
      chk("pp_head", 64'(cdb_tag), 64'(i - 2));
      tick();
      chk("pp_count", 64'(count), 64'd2);
    end
    in_vld = 1'b0;
    tick();
    tick();
    chk("pp_drained", 64'(count), 64'd0);

    // 5: flush with colliding push and grant
    cdb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; in_tag = 4'(i + 8); in_wdata = 32'hF000 + 32'(i);
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_vld = 1'b1; cdb_rdy = 1'b1; in_tag = 4'hC;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_req", 64'(cdb_req), 64'd0);
    tick();
    chk("flush_no_push", 64'(count), 64'd0);

    // 6: random traffic including occasional flush and reset
    for (int c = 0; c < 10000; c++) begin
      in_vld   = 1'($urandom_range(0, 1));
      cdb_rdy  = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_tag   = 4'($urandom);
      in_wdata = $urandom;
      flush    = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 511) != 0);
      tick();
    end
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; cdb_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("final_count", 64'(count), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
